// File: rtl/clk_divider_prog.sv
// Programmable divided-clock / clock-enable generator with load/ack divisor handshake.
// Define CLKDIV_TICK_EN to add the one-cycle `tick` strobe at the start of each period.
module clk_divider_prog #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_load,
    output logic             div_ack,
    output logic             out_clk
`ifdef CLKDIV_TICK_EN
    ,
    output logic             tick
`endif
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    // Divisors below 2 cannot form a high and a low phase, so they saturate to 2.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    // One extra bit so that half(2^WIDTH-1) does not overflow.
    function automatic logic [WIDTH:0] half_div(input logic [WIDTH-1:0] d);
        return ({1'b0, d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
    endfunction

    logic [WIDTH-1:0] cnt, cnt_nxt;
    logic [WIDTH-1:0] div_reg, div_nxt;
    logic [WIDTH-1:0] pend_div, pend_div_nxt;
    logic             pend_vld, pend_vld_nxt;
    logic             out_nxt;
    logic             ack_nxt;
    logic             wrap;
    logic             have_new;
    logic [WIDTH-1:0] new_div;
    logic [WIDTH-1:0] load_val;

    assign wrap     = (cnt == div_reg - WIDTH'(1));
    assign load_val = clamp_div(div_in);
    assign have_new = div_load | pend_vld;
    // A load arriving on the apply edge bypasses the pending register.
    assign new_div  = div_load ? load_val : pend_div;

    always_comb begin
        cnt_nxt      = cnt;
        div_nxt      = div_reg;
        pend_div_nxt = div_load ? load_val : pend_div;
        pend_vld_nxt = pend_vld | div_load;
        out_nxt      = out_clk;
        ack_nxt      = 1'b0;
        if (en) begin
            if (wrap) begin
                cnt_nxt = '0;
                out_nxt = 1'b1;
                if (have_new) begin
                    div_nxt      = new_div;
                    pend_vld_nxt = 1'b0;
                    ack_nxt      = 1'b1;
                end
            end else begin
                cnt_nxt = cnt + WIDTH'(1);
                out_nxt = ({1'b0, cnt_nxt} < half_div(div_reg));
            end
        end else if (have_new) begin
            // Frozen divider: apply at once and restart a clean period.
            div_nxt      = new_div;
            pend_vld_nxt = 1'b0;
            cnt_nxt      = '0;
            out_nxt      = 1'b1;
            ack_nxt      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            div_reg  <= DEF_DIV;
            pend_div <= DEF_DIV;
            pend_vld <= 1'b0;
            out_clk  <= 1'b1;
            div_ack  <= 1'b0;
        end else begin
            cnt      <= cnt_nxt;
            div_reg  <= div_nxt;
            pend_div <= pend_div_nxt;
            pend_vld <= pend_vld_nxt;
            out_clk  <= out_nxt;
            div_ack  <= ack_nxt;
        end
    end

`ifdef CLKDIV_TICK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tick <= 1'b0;
        end else begin
            tick <= en & wrap;
        end
    end
`endif

endmodule

// File: tb/tb_clk_divider_prog.sv
// Directed self-checking bench for clk_divider_prog (WIDTH=8, DEFAULT_DIV=2).
module tb_clk_divider_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] div_in;
    logic       div_load;
    logic       div_ack;
    logic       out_clk;
`ifdef CLKDIV_TICK_EN
    logic       tick;
`endif

    int n_cmp = 0;
    int n_err = 0;

    clk_divider_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .div_in   (div_in),
        .div_load (div_load),
        .div_ack  (div_ack),
        .out_clk  (out_clk)
`ifdef CLKDIV_TICK_EN
        ,
        .tick     (tick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_tick(input string tag, input logic exp);
`ifdef CLKDIV_TICK_EN
        chk(tag, 32'(tick), 32'(exp));
`else
        if (tag.len() < 0) $display("%0d", exp);
`endif
    endtask

    // Called at the first high cycle of a period; runs exactly one period.
    task automatic expect_period(input string tag, input int hi, input int lo);
        for (int i = 1; i <= hi + lo; i++) begin
            step();
            chk({tag, "_out"}, 32'(out_clk), 32'((i < hi) || (i == hi + lo)));
            chk({tag, "_ack"}, 32'(div_ack), 32'd0);
            chk_tick({tag, "_tick"}, (i == hi + lo));
        end
    endtask

    // Caller drives div_load for the first edge; measures edges until div_ack.
    task automatic wait_ack(input string tag, input int exp_lat);
        int n;
        step();
        n = 1;
        div_load = 1'b0;
        while (!div_ack && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
        chk({tag, "_ack"}, 32'(div_ack), 32'd1);
    endtask

    initial begin
        reset    = 1'b0;
        en       = 1'b0;
        div_in   = 8'd0;
        div_load = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", 32'(out_clk), 32'd1);
        chk("rst_ack", 32'(div_ack), 32'd0);
        chk_tick("rst_tick", 1'b0);

        // Default divide-by-2: 1,0,1,0 with tick on every return high.
        reset = 1'b1;
        en    = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("d2_out", 32'(out_clk), 32'((i % 2) == 0));
            chk("d2_ack", 32'(div_ack), 32'd0);
            chk_tick("d2_tick", ((i % 2) == 0));
        end

        // Load 5 at cnt=0 of a div-2 period: applied at the wrap one edge later.
        div_in   = 8'd5;
        div_load = 1'b1;
        wait_ack("ld5", 2);
        chk("ld5_out", 32'(out_clk), 32'd1);
        chk_tick("ld5_tick", 1'b1);
        expect_period("div5", 3, 2);
        expect_period("div5b", 3, 2);

        // Load 4 then 7 in one period: only 7 lands, single ack.
        div_in   = 8'd4;
        div_load = 1'b1;
        step();
        chk("l47_o1", 32'(out_clk), 32'd1);
        chk("l47_a1", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        step();
        chk("l47_o2", 32'(out_clk), 32'd1);
        div_in   = 8'd7;
        div_load = 1'b1;
        step();
        chk("l47_o3", 32'(out_clk), 32'd0);
        chk("l47_a3", 32'(div_ack), 32'd0);
        div_load = 1'b0;
        step();
        chk("l47_o4", 32'(out_clk), 32'd0);
        chk("l47_a4", 32'(div_ack), 32'd0);
        step();
        chk("l47_o5", 32'(out_clk), 32'd1);
        chk("l47_a5", 32'(div_ack), 32'd1);
        expect_period("div7", 4, 3);
        expect_period("div7b", 4, 3);

        // div_in=0 clamps to 2; latency spans the whole current period of 7.
        div_in   = 8'd0;
        div_load = 1'b1;
        wait_ack("ld0", 7);
        chk("ld0_out", 32'(out_clk), 32'd1);
        expect_period("div0", 1, 1);
        expect_period("div0b", 1, 1);

        // Maximum divisor: high 128, low 127.
        div_in   = 8'd255;
        div_load = 1'b1;
        wait_ack("ld255", 2);
        expect_period("div255", 128, 127);

        // Load exactly on the wrap edge is applied at that wrap.
        repeat (254) step();
        chk("pre_byp_out", 32'(out_clk), 32'd0);
        div_in   = 8'd3;
        div_load = 1'b1;
        wait_ack("byp", 1);
        chk("byp_out", 32'(out_clk), 32'd1);
        expect_period("div3", 2, 1);
        expect_period("div3b", 2, 1);

        // Freeze 10 cycles in the high phase, then resume the same phase.
        step();
        chk("frz_pre", 32'(out_clk), 32'd1);
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("frz_out", 32'(out_clk), 32'd1);
            chk("frz_ack", 32'(div_ack), 32'd0);
            chk_tick("frz_tick", 1'b0);
        end
        en = 1'b1;
        step();
        chk("res_o1", 32'(out_clk), 32'd0);
        step();
        chk("res_o2", 32'(out_clk), 32'd1);
        chk_tick("res_t2", 1'b1);

        // Load while frozen in the low phase: ack next cycle, out forced high.
        step();
        step();
        chk("en0_pre", 32'(out_clk), 32'd0);
        en       = 1'b0;
        div_in   = 8'd4;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("en0_ack", 32'(div_ack), 32'd1);
        chk("en0_out", 32'(out_clk), 32'd1);
        chk_tick("en0_tick", 1'b0);
        step();
        chk("en0_ack2", 32'(div_ack), 32'd0);
        chk("en0_out2", 32'(out_clk), 32'd1);
        en = 1'b1;
        expect_period("div4", 2, 2);

        // Reset mid-period with a load pending: discarded, no ack afterwards.
        step();
        div_in   = 8'd9;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("prerst_out", 32'(out_clk), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_out", 32'(out_clk), 32'd1);
        chk("arst_ack", 32'(div_ack), 32'd0);
        step();
        step();
        chk("arst_out2", 32'(out_clk), 32'd1);
        reset = 1'b1;
        expect_period("post_rst", 1, 1);
        expect_period("post_rst2", 1, 1);
        expect_period("post_rst3", 1, 1);
        expect_period("post_rst4", 1, 1);
        expect_period("post_rst5", 1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/clk_divider_prog.md
# clk_divider_prog

Programmable clock-enable/divided-clock generator, successor to the fixed divide-by-2 block. Produces a divided square wave `out_clk` of period `div` input-clock cycles, programmable at run time through a load/ack handshake, plus an optional one-cycle `tick` strobe per period. Sits beside the system clock tree feeding slow peripherals (display scan, debouncers, UART baud gating) as a clock-enable source; `out_clk` is a logic signal, not a clock-network driver.

## Interface
- `WIDTH`, 8: width of the divisor and internal counter.
- `DEFAULT_DIV`, 2: divisor after reset; must be in 2..2^WIDTH-1.

- `clk`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `en`  in  1  count enable; 0 freezes the divider.
- `div_in`  in  WIDTH  new divisor value.
- `div_load`  in  1  one-cycle request to load `div_in`.
- `div_ack`  out  1  one-cycle pulse: new divisor has taken effect.
- `out_clk`  out  1  divided clock, registered.
- `tick`  out  1  one-cycle strobe at start of each period (only with `CLKDIV_TICK_EN`).

## Operation
- Registers: `cnt` (WIDTH), `div_reg` (WIDTH), `pend_div` (WIDTH), `pend_vld`, `out_clk`, `div_ack`, `tick`.
- Reset (`reset`=0, async): `cnt`=0, `div_reg`=DEFAULT_DIV, `pend_vld`=0, `out_clk`=1, `div_ack`=0, `tick`=0.
- `half(d)` = (d+1)>>1. `out_clk` = 1 while `cnt` < `half(div_reg)`, else 0; odd divisors give the extra cycle to the high phase.
- Count (en=1): `cnt` increments; at `cnt`=`div_reg`-1 it wraps to 0 ("wrap").
- Load: `div_load`=1 captures `div_in` into `pend_div`, sets `pend_vld`. Values 0 and 1 are clamped to 2 at capture. A later `div_load` while pending overwrites `pend_div` (latest wins, single ack).
- Apply, en=1: at the next wrap `div_reg`<=`pend_div`, `pend_vld`<=0; the period starting at that wrap uses the new divisor. `div_load` in the same cycle as a wrap is applied at that wrap (bypass).
- Apply, en=0: pending divisor applied on the next edge; `cnt` forced to 0, `out_clk` to 1.
- en=0 otherwise: `cnt`, `out_clk` hold; `tick`=0.
- `tick`: 1 in the cycle `cnt`=0 following a wrap (coincides with `out_clk` rising); never after reset or en=0 apply.

## Timing
- All outputs registered; no combinational input-to-output path.
- First rising edge after reset release with en=1: `cnt`=1; for div=2, `out_clk` sequence from reset is 1,0,1,0… (toggles every cycle).
- Wrap edge N: `out_clk`=1, `tick`=1, and if a divisor was applied, `div_ack`=1 — all visible in the cycle after edge N.
- `div_load` → `div_ack` latency: 1 cycle (en=0 or load on wrap cycle) up to current `div_reg` cycles.
- Reset asserted mid-period or with a load pending: pending request discarded, no `div_ack` issued.
- Divisor change never produces a runt pulse: high/low phases of each period always match `half` of that period's divisor.

## Configuration
- `CLKDIV_TICK_EN` defined: `tick` port and register present as above.
- Not defined: `tick` port and logic removed; all other behaviour identical.

## Test plan
- Reset, en=1, DEFAULT_DIV=2 → `out_clk` 1,0,1,0…; with macro, `tick` high every other cycle starting at the 2nd cycle after release.
- Load div=5 while div=2 running → applied at next wrap; `out_clk` 1,1,1,0,0 repeating; `div_ack` one pulse coincident with first new-period high.
- Load 4 then 7 within one period → only 7 applied, single `div_ack`; period 7 (high 4, low 3).
- Load div_in=0 → behaves as div=2; load div_in=255 (WIDTH=8) → period 255, high 128 cycles.
- en=0 for 10 cycles mid-high-phase → `out_clk`, `cnt` frozen, `tick`=0; resume continues same phase; load during en=0 → `div_ack` next cycle, `out_clk`=1, `cnt`=0.
- Assert `reset` low mid-period with load pending → immediately `out_clk`=1, `div_ack`=0; after release divisor = DEFAULT_DIV, no ack.
